softmax_max_subtract_stream: RTL



---
 rtl/softmax_max_subtract_stream.sv | 105 ++++++++++
 1 files changed

// File: rtl/softmax_max_subtract_stream.sv
// Softmax max-subtract stage: captures a score vector and its maximum, then
// streams saturated (x_i - max) one element per valid/ready beat.
module softmax_max_subtract_stream #(
    parameter int N = 64,
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*W-1:0]   in_data,
    input  logic [W-1:0]     in_max,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [5:0]       out_index,
    output logic             out_last,
    output logic             out_pos_clamp
);

    localparam int IW = 6;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_e;

    state_e               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [N*W-1:0]       vec_q, vec_d;
    logic [W-1:0]         max_q, max_d;

    logic [W-1:0]         elem;
    logic signed [W:0]    diff;
    logic                 pos_clamp;
    logic                 neg_sat;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        vec_d     = vec_q;
        max_d     = max_q;
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == STREAM);
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    vec_d   = in_data;
                    max_d   = in_max;
                    idx_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    // The vector store is an ordinary register bank, so it is reset like the rest of the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            vec_q   <= '0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
            max_q   <= max_d;
        end
    end

    // Outputs derive only from registered state; the difference is kept at W+1 bits.
    assign elem      = vec_q[int'(idx_q) * W +: W];
    assign diff      = {elem[W-1], elem} - {max_q[W-1], max_q};
    assign pos_clamp = !diff[W] && (diff != '0);
    assign neg_sat   = diff[W] && !diff[W-1];

    always_comb begin
        out_data = diff[W-1:0];
        if (pos_clamp) begin
            out_data = '0;
        end else if (neg_sat) begin
            out_data = {1'b1, {(W-1){1'b0}}};
        end
    end

    assign out_pos_clamp = pos_clamp && (state_q == STREAM);
    assign out_index     = idx_q;
    assign out_last      = (state_q == STREAM) && (idx_q == LAST_IDX);

endmodule
